// File: rtl/extend_pkg.sv
// Shared types and helpers for the pipelined immediate extender.
// Mode encoding matches the instruction ImmSrc field.
package extend_pkg;

    typedef enum logic [1:0] {
        IMM_DP   = 2'b00,
        IMM_MEM  = 2'b01,
        IMM_BR   = 2'b10,
        IMM_MEMS = 2'b11
    } imm_src_t;

    localparam int unsigned ROT_STEP = 2;

    // Rotate right within 32 bits; an amount of 0 returns x unchanged.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] t;
        t = {x, x} >> amt;
        return t[31:0];
    endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate decode: extension, DP rotation and shifter carry-out.
// Placed between the raw-field stage and the result stage of extend_pipe.
module imm_extend_core
    import extend_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit ROT_EN = 1'b1
) (
    input  logic [23:0]       imm_i,
    input  imm_src_t          src_i,
    output logic [DATA_W-1:0] ext_o,
    output logic              rot_c_o
);

    logic [4:0]  rot_amt_s;
    logic [31:0] dp_rot_s;

    assign rot_amt_s = 5'(ROT_STEP * 32'(imm_i[11:8]));
    assign dp_rot_s  = ror32({24'h00_0000, imm_i[7:0]}, rot_amt_s);

    // Mode decode; carry-out is only meaningful for a non-zero DP rotation.
    always_comb begin
        ext_o   = '0;
        rot_c_o = 1'b0;
        case (src_i)
            IMM_DP: begin
                if (ROT_EN) begin
                    ext_o   = DATA_W'(dp_rot_s);
                    rot_c_o = (imm_i[11:8] != 4'h0) ? dp_rot_s[31] : 1'b0;
                end else begin
                    ext_o   = DATA_W'(imm_i[7:0]);
                    rot_c_o = 1'b0;
                end
            end
            IMM_MEM:  ext_o = DATA_W'(imm_i[11:0]);
            IMM_BR:   ext_o = {{(DATA_W-26){imm_i[23]}}, imm_i, 2'b00};
            IMM_MEMS: ext_o = {{(DATA_W-12){imm_i[11]}}, imm_i[11:0]};
            default: begin
                ext_o   = '0;
                rot_c_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/extend_pipe.sv
// Two-stage valid/ready immediate extender between decode and execute.
// S1 holds the raw field, S2 holds the extended result and drives the outputs.
module extend_pipe
    import extend_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter bit ROT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       Imm,
    input  logic [1:0]        ImmSrc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ExtImm,
    output logic              rot_c,
    output logic [TAG_W-1:0]  out_tag
);

    logic              s1_valid_q, s1_valid_d;
    logic [23:0]       s1_imm_q, s1_imm_d;
    imm_src_t          s1_src_q, s1_src_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_ext_q, s2_ext_d;
    logic              s2_rotc_q, s2_rotc_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

    logic              s2_load_s;
    logic              s1_adv_s;
    logic              accept_s;
    logic [DATA_W-1:0] core_ext_s;
    logic              core_rotc_s;

    imm_extend_core #(
        .DATA_W (DATA_W),
        .ROT_EN (ROT_EN)
    ) u_core (
        .imm_i   (s1_imm_q),
        .src_i   (s1_src_q),
        .ext_o   (core_ext_s),
        .rot_c_o (core_rotc_s)
    );

    // An empty S2 always loads, so bubbles never hold back a following item.
    assign s2_load_s = !s2_valid_q || out_ready;
    assign s1_adv_s  = s1_valid_q && s2_load_s;
    assign in_ready  = !s1_valid_q || s2_load_s;
    assign accept_s  = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign ExtImm    = s2_ext_q;
    assign rot_c     = s2_rotc_q;
    assign out_tag   = s2_tag_q;

    // Next-state for both stages.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_src_d   = s1_src_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_ext_d   = s2_ext_q;
        s2_rotc_d  = s2_rotc_q;
        s2_tag_d   = s2_tag_q;

        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_imm_d   = Imm;
            s1_src_d   = imm_src_t'(ImmSrc);
            s1_tag_d   = in_tag;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        // Result registers only change when a real item moves in, keeping outputs quiet otherwise.
        if (s1_adv_s) begin
            s2_ext_d  = core_ext_s;
            s2_rotc_d = core_rotc_s;
            s2_tag_d  = s1_tag_q;
        end else begin
            s2_ext_d  = s2_ext_q;
            s2_rotc_d = s2_rotc_q;
            s2_tag_d  = s2_tag_q;
        end
    end

    // Stage registers; reset discards in-flight items immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= 24'h00_0000;
            s1_src_q   <= IMM_DP;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_ext_q   <= '0;
            s2_rotc_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_src_q   <= s1_src_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_ext_q   <= s2_ext_d;
            s2_rotc_q  <= s2_rotc_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

endmodule
